// File: rtl/logic_unit_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter_if
// Description : Request/operand/result bundle between four requesters, the
//               logic-unit arbiter, and the downstream result consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_unit_arbiter_if;
    logic [3:0]   req;   // per-requester request
    logic [7:0]   op;    // op[2i+1:2i] opcode of requester i
    logic [127:0] a;     // a[32i+31:32i] operand A of requester i
    logic [127:0] b;     // b[32i+31:32i] operand B of requester i
    logic         rdy;   // downstream ready
    logic [3:0]   gnt;   // one-hot grant (combinational)
    logic [31:0]  y;     // registered result
    logic [1:0]   id;    // requester that produced y
    logic         vld;   // y/id valid
    logic [15:0]  cnt;   // results delivered

    // Requester/consumer side
    modport master (
        output req, op, a, b, rdy,
        input  gnt, y, id, vld, cnt
    );

    // Arbiter side
    modport slave (
        input  req, op, a, b, rdy,
        output gnt, y, id, vld, cnt
    );
endinterface
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter
// Description : Round-robin arbiter over four requesters feeding a shared
//               32-bit bitwise logic unit (AND/OR/NOR/INV) with a single-entry
//               registered result stage and a delivered-result counter.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter (
    input  wire logic           clk_i,
    input  wire logic           rst_ni,   // synchronous, active-low
    logic_unit_arbiter_if.slave bus
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOR = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t      state_q;
    logic        vld_q;
    logic [31:0] y_q;
    logic [1:0]  id_q;
    logic [15:0] cnt_q;
    logic [1:0]  ptr_q;

    logic        w_open;
    logic        w_hit;
    logic [1:0]  w_gnt_idx;
    logic        w_grant;
    logic [3:0]  w_gnt;
    logic [1:0]  w_sel_op;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic [31:0] w_result;
    logic [1:0]  ptr_d;

    // Round-robin search starting at the pointer; grant only when the stage can accept
    always_comb begin
        w_open    = !vld_q || bus.rdy;
        w_hit     = 1'b0;
        w_gnt_idx = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!w_hit && bus.req[ptr_q + 2'(k)]) begin
                w_hit     = 1'b1;
                w_gnt_idx = ptr_q + 2'(k);
            end
        end
        // Reset forces the grant low so no requester believes it was served
        w_grant = rst_ni && w_open && w_hit;
        w_gnt   = '0;
        if (w_grant) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
        ptr_d = w_gnt_idx + 2'd1;
    end

    // Steer the winning requester's opcode and operands into the logic unit
    always_comb begin
        w_sel_op = bus.op[1:0];
        w_sel_a  = bus.a[31:0];
        w_sel_b  = bus.b[31:0];
        case (w_gnt_idx)
            2'd0: begin
                w_sel_op = bus.op[1:0];
                w_sel_a  = bus.a[31:0];
                w_sel_b  = bus.b[31:0];
            end
            2'd1: begin
                w_sel_op = bus.op[3:2];
                w_sel_a  = bus.a[63:32];
                w_sel_b  = bus.b[63:32];
            end
            2'd2: begin
                w_sel_op = bus.op[5:4];
                w_sel_a  = bus.a[95:64];
                w_sel_b  = bus.b[95:64];
            end
            default: begin
                w_sel_op = bus.op[7:6];
                w_sel_a  = bus.a[127:96];
                w_sel_b  = bus.b[127:96];
            end
        endcase
    end

    // Bitwise logic unit; operand B is unused for INV
    always_comb begin
        w_result = '0;
        case (w_sel_op)
            OP_AND:  w_result = w_sel_a & w_sel_b;
            OP_OR:   w_result = w_sel_a | w_sel_b;
            OP_NOR:  w_result = ~(w_sel_a | w_sel_b);
            OP_INV:  w_result = ~w_sel_a;
            default: w_result = '0;
        endcase
    end

    // Result-stage FSM, round-robin pointer and delivery counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            vld_q   <= 1'b0;
            y_q     <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            // A result leaves whenever it is valid and the consumer is ready
            if (vld_q && bus.rdy) begin
                cnt_q <= cnt_q + 16'd1;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (w_grant) begin
                        state_q <= ST_FULL;
                        vld_q   <= 1'b1;
                        y_q     <= w_result;
                        id_q    <= w_gnt_idx;
                        ptr_q   <= ptr_d;
                    end
                end
                ST_FULL: begin
                    if (w_grant) begin
                        // Drain and refill in the same cycle: stage stays full
                        state_q <= ST_FULL;
                        vld_q   <= 1'b1;
                        y_q     <= w_result;
                        id_q    <= w_gnt_idx;
                        ptr_q   <= ptr_d;
                    end else if (bus.rdy) begin
                        // Drained with nothing to replace it; Y/ID keep last value
                        state_q <= ST_EMPTY;
                        vld_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt = w_gnt;
    assign bus.y   = y_q;
    assign bus.id  = id_q;
    assign bus.vld = vld_q;
    assign bus.cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_arbiter
// Description : Self-checking bench for logic_unit_arbiter: vector table of
//               single operations plus round-robin, backpressure, reset and
//               counter-wrap sequences, with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic_unit_arbiter_if bus ();

    logic_unit_arbiter dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] y;
        logic [1:0]  id;
    } res_t;
    res_t sb[$];

    typedef struct {
        logic [3:0]  req;
        int          idx;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_y;
    } vec_t;
    vec_t vecs[8];

    logic [1:0]  rop[4];
    logic [31:0] ra[4];
    logic [31:0] rb[4];
    logic [3:0]  rr_seq[5];
    res_t        held;
    int          exp_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_f(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a | b);
            default: return ~a;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        bus.op[2*i +: 2] = op;
        bus.a[32*i +: 32] = a;
        bus.b[32*i +: 32] = b;
    endtask

    // Pops the oldest expected result and compares it with the stage contents
    task automatic pop_check(input string tag, output res_t r);
        r = '0;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got y=%h id=%0d expected an entry", tag, bus.y, bus.id);
        end else begin
            r = sb.pop_front();
            if (bus.y !== r.y || bus.id !== r.id) begin
                n_fail++;
                $display("FAIL %s: got y=%h id=%0d expected y=%h id=%0d", tag, bus.y, bus.id, r.y, r.id);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        res_t r;
        vecs[0] = '{4'b0001, 0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
        vecs[1] = '{4'b0100, 2, 2'b01, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFFFF};
        vecs[2] = '{4'b0100, 2, 2'b10, 32'h0000FFFF, 32'h00FF00FF, 32'hFF000000};
        vecs[3] = '{4'b0100, 2, 2'b11, 32'h0000FFFF, 32'h00FF00FF, 32'hFFFF0000};
        vecs[4] = '{4'b0100, 2, 2'b00, 32'h0000FFFF, 32'h00FF00FF, 32'h000000FF};
        vecs[5] = '{4'b1000, 3, 2'b01, 32'h12340000, 32'h00005678, 32'h12345678};
        vecs[6] = '{4'b0010, 1, 2'b11, 32'hA5A5A5A5, 32'h00000000, 32'h5A5A5A5A};
        vecs[7] = '{4'b0001, 0, 2'b10, 32'h0F0F0000, 32'h00000F0F, 32'hF0F0F0F0};
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;

        // Reset with everyone requesting: no grant, all state cleared
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        bus.op  = '0;
        bus.a   = '0;
        bus.b   = '0;
        bus.rdy = 1'b1;
        tick();
        tick();
        check("reset_gnt", 32'(bus.gnt), 32'h0);
        check("reset_vld", 32'(bus.vld), 32'h0);
        check("reset_y",   bus.y,        32'h0);
        check("reset_id",  32'(bus.id),  32'h0);
        check("reset_cnt", 32'(bus.cnt), 32'h0);
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        tick();

        // Table of single operations: grant same cycle, result next, counted after
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            bus.req = vecs[i].req;
            bus.rdy = 1'b1;
            set_port(vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            check($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].req));
            sb.push_back('{y: vecs[i].exp_y, id: 2'(vecs[i].idx)});
            tick();
            bus.req = 4'b0000;
            #1;
            check($sformatf("vec%0d_vld", i), 32'(bus.vld), 32'h1);
            pop_check($sformatf("vec%0d_res", i), r);
            tick();
            exp_cnt++;
            check($sformatf("vec%0d_vld_drained", i), 32'(bus.vld), 32'h0);
            check($sformatf("vec%0d_cnt", i), 32'(bus.cnt), 32'(exp_cnt));
        end

        // Round-robin with all four requesting from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rop[i] = 2'(i);
            ra[i]  = 32'(32'h11111111 * (i + 1));
            rb[i]  = 32'h0F0F0F0F ^ 32'(i);
            set_port(i, rop[i], ra[i], rb[i]);
        end
        bus.req = 4'b1111;
        bus.rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rr%0d_gnt", k), 32'(bus.gnt), 32'(rr_seq[k]));
            if (k >= 1) begin
                check($sformatf("rr%0d_vld", k), 32'(bus.vld), 32'h1);
                check($sformatf("rr%0d_cnt", k), 32'(bus.cnt), 32'(k - 1));
                pop_check($sformatf("rr%0d_res", k), r);
            end
            sb.push_back('{y: ref_f(rop[k % 4], ra[k % 4], rb[k % 4]), id: 2'(k % 4)});
            tick();
        end

        // Backpressure: stage full, consumer stalls, requester 1 waits
        bus.req = 4'b0010;
        bus.rdy = 1'b0;
        #1;
        check("rr_cnt4", 32'(bus.cnt), 32'd4);
        pop_check("rr4_res", held);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_gnt", k), 32'(bus.gnt), 32'h0);
            check($sformatf("bp%0d_vld", k), 32'(bus.vld), 32'h1);
            check($sformatf("bp%0d_y", k),   bus.y,        held.y);
            check($sformatf("bp%0d_id", k),  32'(bus.id),  32'(held.id));
            tick();
        end
        check("bp_cnt_hold", 32'(bus.cnt), 32'd4);
        bus.rdy = 1'b1;
        #1;
        check("bp_release_gnt", 32'(bus.gnt), 32'b0010);
        sb.push_back('{y: ref_f(rop[1], ra[1], rb[1]), id: 2'd1});
        tick();
        check("bp_release_cnt", 32'(bus.cnt), 32'd5);
        pop_check("bp_release_res", r);

        // Two more grants to requester 1 take the count to 7 and the pointer to 2
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("pre%0d_gnt", k), 32'(bus.gnt), 32'b0010);
            sb.push_back('{y: ref_f(rop[1], ra[1], rb[1]), id: 2'd1});
            tick();
            pop_check($sformatf("pre%0d_res", k), r);
        end
        bus.req = 4'b0000;
        bus.rdy = 1'b0;
        #1;
        check("pre_cnt7", 32'(bus.cnt), 32'd7);
        check("pre_vld",  32'(bus.vld), 32'h1);

        // Reset mid-operation discards the held result and rewinds the pointer
        rst_n   = 1'b0;
        bus.req = 4'b1010;
        #1;
        check("midrst_gnt_in_reset", 32'(bus.gnt), 32'h0);
        tick();
        rst_n   = 1'b1;
        #1;
        check("midrst_vld", 32'(bus.vld), 32'h0);
        check("midrst_cnt", 32'(bus.cnt), 32'h0);
        check("midrst_y",   bus.y,        32'h0);
        check("midrst_id",  32'(bus.id),  32'h0);
        check("midrst_gnt", 32'(bus.gnt), 32'b0010);
        bus.req = 4'b0000;
        tick();
        tick();

        // Counter wrap: continuous single-requester traffic
        do_reset();
        set_port(0, 2'b00, 32'hFFFFFFFF, 32'h0000FFFF);
        bus.req = 4'b0001;
        bus.rdy = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        check("wrap_cnt_ffff", 32'(bus.cnt), 32'h0000FFFF);
        check("wrap_vld",      32'(bus.vld), 32'h1);
        check("wrap_y",        bus.y,        32'h0000FFFF);
        tick();
        check("wrap_cnt_0",    32'(bus.cnt), 32'h0);
        bus.req = 4'b0000;
        tick();
        tick();
        check("wrap_drained",  32'(bus.vld), 32'h0);
        check("sb_empty",      32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
